gcn_data_server: RTL and testbench
==================================

GCN_DATA_SERVER -- requirements
Module: gcn_data_server

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- WEIGHT_ROWS, 96, elements per row/column.
- WEIGHT_COLS, 3, weight columns.
- FEATURE_ROWS, 6, feature rows.
- WEIGHT_WIDTH, 5, element bits.
- LANES, 8, elements per load beat.
- ADDRESS_WIDTH, 13, read address bits.
- FEATURE_BASE, 512, first feature address.
- COO_NUM_OF_COLS, 6, edges.
- COO_BW, 3, node index bits.
REQ-002 SHALL have ports (name direction width meaning):
- clk in 1: clock.
- reset in 1: async active-high reset.
- load_start in 1: begin load session.
- load_valid in 1: load beat valid.
- load_ready out 1: block accepts beat.
- load_data in LANES*WEIGHT_WIDTH: lane k at bits [k*5+:5].
- gcn_start out 1: one-cycle start to GCN.
- gcn_done in 1: GCN completion.
- read_address in ADDRESS_WIDTH: GCN read address.
- enable_read in 1: GCN read strobe.
- data_out out WEIGHT_ROWS x WEIGHT_WIDTH: row/column served.
- coo_address in COO_BW: COO column requested.
- coo_out out 2 x COO_BW: [0]=src, [1]=dst.
- busy out 1: state not IDLE/DONE.
- addr_error out 1: sticky illegal-read flag.
REQ-003 SHALL use one clock, clk; reset SHALL be asynchronous and active-high, named reset.

Function
REQ-004 SHALL implement FSM states IDLE, LOAD_WM, LOAD_FM, LOAD_COO, START, RUN, DONE.
REQ-005 IDLE or DONE with load_start=1 SHALL go to LOAD_WM and clear addr_error and the beat counter; load_start in other states SHALL be ignored.
REQ-006 load_ready SHALL be 1 exactly in LOAD_WM, LOAD_FM, LOAD_COO; a beat is accepted only when load_valid and load_ready are both 1.
REQ-007 LOAD_WM SHALL accept WEIGHT_COLS*WEIGHT_ROWS/LANES (36) beats, column-major, column 0 first, lanes filling element indices beat*LANES+k; the 36th beat SHALL move the state to LOAD_FM.
REQ-008 LOAD_FM SHALL accept FEATURE_ROWS*WEIGHT_ROWS/LANES (72) beats in the same order, then go to LOAD_COO.
REQ-009 LOAD_COO SHALL accept COO_NUM_OF_COLS (6) beats, each with src in bits [COO_BW-1:0] and dst in bits [2*COO_BW-1:COO_BW], then go to START.
REQ-010 START SHALL last one cycle with gcn_start=1, then go to RUN; gcn_start SHALL be 0 in every other state.
REQ-011 RUN SHALL go to DONE on the first cycle gcn_done=1; gcn_done in other states SHALL be ignored.
REQ-012 In RUN only, an enable_read=1 cycle SHALL update data_out on the next edge: address a<WEIGHT_COLS gives weight column a; FEATURE_BASE<=a<FEATURE_BASE+FEATURE_ROWS gives feature row a-FEATURE_BASE; otherwise all zeros and addr_error set.
REQ-013 data_out SHALL hold its value on cycles with no qualifying read.
REQ-014 In RUN, coo_out SHALL register the edge at coo_address every cycle (1-cycle latency); coo_address>=COO_NUM_OF_COLS SHALL give zeros and set addr_error.
REQ-015 Beat counter SHALL reset to 0 at each phase change and never wrap inside a phase.
REQ-016 busy SHALL be 1 in LOAD_WM through RUN.

Reset
REQ-017 Reset SHALL asynchronously force state IDLE and zero the beat counter, load_ready, gcn_start, busy, addr_error, data_out and coo_out.
REQ-018 Storage arrays SHALL NOT be reset; reset mid-load SHALL abandon the session, and a fresh load_start is required.

Structure
REQ-019 The state enum and default constants (FEATURE_BASE, LANES) SHALL live in shared package gcn_pkg.
REQ-020 Element storage SHALL be one sub-module, gcn_row_store: lane-write port plus one registered whole-row read port, instantiated twice (WM 3 rows, FM 6 rows).

Verification
REQ-021 Bench SHALL cover:
- Full load with element value (idx mod 32), 114 beats with load_valid constant 1 -> gcn_start pulses exactly once, 1 cycle after the final COO beat.
- Load with load_valid toggling 1/0 -> same final contents, with beat count 114.
- RUN, read_address=1 -> data_out equals weight column 1 on the next cycle; read_address=517 -> feature row 5.
- RUN, read_address=3 -> data_out all zeros and addr_error=1 until next load_start.
- RUN, coo_address=4 after edge (2,5) loaded at column 4 -> coo_out={2,5} the next cycle.
- Reset asserted after 50 beats -> state IDLE, load_ready=0; gcn_done pulses and reads are ignored until a new load completes.

Source files
------------

// File: rtl/gcn_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gcn_pkg
// Brief   : Shared FSM state, read-select encoding and default geometry for
//           the GCN data server.
// Rev     : 1.0
// ============================================================================
package gcn_pkg;

  localparam int GCN_LANES        = 8;
  localparam int GCN_FEATURE_BASE = 512;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_WM  = 3'd1,
    ST_LOAD_FM  = 3'd2,
    ST_LOAD_COO = 3'd3,
    ST_START    = 3'd4,
    ST_RUN      = 3'd5,
    ST_DONE     = 3'd6
  } gcn_state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_WM   = 2'd1,
    SEL_FM   = 2'd2
  } gcn_sel_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gcn_row_store.sv
`default_nettype none
// ============================================================================
// Module  : gcn_row_store
// Brief   : Row-major element store with a lane-wide write port and one
//           registered whole-row read port.
// Rev     : 1.0
// ============================================================================
module gcn_row_store
  import gcn_pkg::*;
#(
  parameter  int ROWS   = 3,
  parameter  int ELEMS  = 96,
  parameter  int WIDTH  = 5,
  parameter  int LANES  = GCN_LANES,
  parameter  int BEAT_W = 7,
  localparam int ROW_W  = idx_w(ROWS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en_i,
  input  logic [BEAT_W-1:0]             wr_beat_i,
  input  logic [LANES*WIDTH-1:0]        wr_data_i,
  input  logic                          rd_en_i,
  input  logic [ROW_W-1:0]              rd_row_i,
  output logic [ELEMS-1:0][WIDTH-1:0]   rd_data_o
);

  localparam int ELEM_W        = idx_w(ELEMS);
  localparam int BEATS_PER_ROW = ELEMS / LANES;

  logic [ROWS-1:0][ELEMS-1:0][WIDTH-1:0] mem_q;
  logic [ROW_W-1:0]                      w_row;
  logic [ELEM_W-1:0]                     w_base;

  // A beat never straddles rows because each row holds a whole number of beats.
  assign w_row  = ROW_W'(wr_beat_i / BEAT_W'(BEATS_PER_ROW));
  assign w_base = ELEM_W'(wr_beat_i % BEAT_W'(BEATS_PER_ROW)) * ELEM_W'(LANES);

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int k = 0; k < LANES; k++) begin
        mem_q[w_row][w_base + ELEM_W'(k)] <= wr_data_i[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_o <= '0;
    end else if (rd_en_i) begin
      rd_data_o <= mem_q[rd_row_i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/gcn_data_server.sv
`default_nettype none
// ============================================================================
// Module  : gcn_data_server
// Brief   : Loads weights, features and COO edges, starts the GCN, then serves
//           its row/column and edge reads.
// Rev     : 1.0
// ============================================================================
module gcn_data_server
  import gcn_pkg::*;
#(
  parameter int WEIGHT_ROWS     = 96,
  parameter int WEIGHT_COLS     = 3,
  parameter int FEATURE_ROWS    = 6,
  parameter int WEIGHT_WIDTH    = 5,
  parameter int LANES           = GCN_LANES,
  parameter int ADDRESS_WIDTH   = 13,
  parameter int FEATURE_BASE    = GCN_FEATURE_BASE,
  parameter int COO_NUM_OF_COLS = 6,
  parameter int COO_BW          = 3
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    load_start,
  input  logic                                    load_valid,
  output logic                                    load_ready,
  input  logic [LANES*WEIGHT_WIDTH-1:0]           load_data,
  output logic                                    gcn_start,
  input  logic                                    gcn_done,
  input  logic [ADDRESS_WIDTH-1:0]                read_address,
  input  logic                                    enable_read,
  output logic [WEIGHT_ROWS-1:0][WEIGHT_WIDTH-1:0] data_out,
  input  logic [COO_BW-1:0]                       coo_address,
  output logic [1:0][COO_BW-1:0]                  coo_out,
  output logic                                    busy,
  output logic                                    addr_error
);

  localparam int WM_BEATS  = WEIGHT_COLS * WEIGHT_ROWS / LANES;
  localparam int FM_BEATS  = FEATURE_ROWS * WEIGHT_ROWS / LANES;
  localparam int MAX_BEATS = (FM_BEATS > WM_BEATS) ? FM_BEATS : WM_BEATS;
  localparam int CNT_W     = $clog2(MAX_BEATS + COO_NUM_OF_COLS + 1);
  localparam int WM_ROW_W  = idx_w(WEIGHT_COLS);
  localparam int FM_ROW_W  = idx_w(FEATURE_ROWS);

  gcn_state_e             state_q, state_d;
  gcn_sel_e               sel_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   load_ready_q, gcn_start_q, busy_q, addr_error_q;
  logic [1:0][COO_BW-1:0] coo_out_q;
  logic [COO_BW-1:0]      coo_src_q [2**COO_BW];
  logic [COO_BW-1:0]      coo_dst_q [2**COO_BW];

  logic w_accept, w_last, w_run, w_is_wm, w_is_fm, w_session;
  logic [WEIGHT_ROWS-1:0][WEIGHT_WIDTH-1:0] w_wm_data, w_fm_data;

  assign w_accept  = load_valid & load_ready_q;
  assign w_run     = (state_q == ST_RUN);
  assign w_session = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && load_start;
  assign w_is_wm   = int'(read_address) < WEIGHT_COLS;
  assign w_is_fm   = (int'(read_address) >= FEATURE_BASE) &&
                     (int'(read_address) < FEATURE_BASE + FEATURE_ROWS);

  always_comb begin
    w_last = 1'b0;
    case (state_q)
      ST_LOAD_WM:  w_last = int'(cnt_q) == WM_BEATS - 1;
      ST_LOAD_FM:  w_last = int'(cnt_q) == FM_BEATS - 1;
      ST_LOAD_COO: w_last = int'(cnt_q) == COO_NUM_OF_COLS - 1;
      default:     w_last = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (load_start)         state_d = ST_LOAD_WM;
      ST_LOAD_WM:       if (w_accept && w_last) state_d = ST_LOAD_FM;
      ST_LOAD_FM:       if (w_accept && w_last) state_d = ST_LOAD_COO;
      ST_LOAD_COO:      if (w_accept && w_last) state_d = ST_START;
      ST_START:                                 state_d = ST_RUN;
      ST_RUN:           if (gcn_done)           state_d = ST_DONE;
      default:                                  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      load_ready_q <= 1'b0;
      gcn_start_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_ready_q <= (state_d == ST_LOAD_WM) || (state_d == ST_LOAD_FM) ||
                      (state_d == ST_LOAD_COO);
      gcn_start_q  <= (state_d == ST_START);
      busy_q       <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (w_accept) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && (state_q == ST_LOAD_COO)) begin
      coo_src_q[cnt_q[COO_BW-1:0]] <= load_data[COO_BW-1:0];
      coo_dst_q[cnt_q[COO_BW-1:0]] <= load_data[2*COO_BW-1:COO_BW];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q        <= SEL_NONE;
      coo_out_q    <= '0;
      addr_error_q <= 1'b0;
    end else begin
      if (w_session) begin
        addr_error_q <= 1'b0;
      end
      if (w_run) begin
        if (enable_read) begin
          if (w_is_wm) begin
            sel_q <= SEL_WM;
          end else if (w_is_fm) begin
            sel_q <= SEL_FM;
          end else begin
            sel_q        <= SEL_NONE;
            addr_error_q <= 1'b1;
          end
        end
        if (int'(coo_address) < COO_NUM_OF_COLS) begin
          coo_out_q <= {coo_dst_q[coo_address], coo_src_q[coo_address]};
        end else begin
          coo_out_q    <= '0;
          addr_error_q <= 1'b1;
        end
      end
    end
  end

  gcn_row_store #(
    .ROWS   (WEIGHT_COLS),
    .ELEMS  (WEIGHT_ROWS),
    .WIDTH  (WEIGHT_WIDTH),
    .LANES  (LANES),
    .BEAT_W (CNT_W)
  ) u_wm_store (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (w_accept && (state_q == ST_LOAD_WM)),
    .wr_beat_i (cnt_q),
    .wr_data_i (load_data),
    .rd_en_i   (w_run && enable_read && w_is_wm),
    .rd_row_i  (WM_ROW_W'(read_address)),
    .rd_data_o (w_wm_data)
  );

  gcn_row_store #(
    .ROWS   (FEATURE_ROWS),
    .ELEMS  (WEIGHT_ROWS),
    .WIDTH  (WEIGHT_WIDTH),
    .LANES  (LANES),
    .BEAT_W (CNT_W)
  ) u_fm_store (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (w_accept && (state_q == ST_LOAD_FM)),
    .wr_beat_i (cnt_q),
    .wr_data_i (load_data),
    .rd_en_i   (w_run && enable_read && !w_is_wm && w_is_fm),
    .rd_row_i  (FM_ROW_W'(read_address - ADDRESS_WIDTH'(FEATURE_BASE))),
    .rd_data_o (w_fm_data)
  );

  always_comb begin
    data_out = '0;
    case (sel_q)
      SEL_WM:  data_out = w_wm_data;
      SEL_FM:  data_out = w_fm_data;
      default: data_out = '0;
    endcase
  end

  assign load_ready = load_ready_q;
  assign gcn_start  = gcn_start_q;
  assign busy       = busy_q;
  assign addr_error = addr_error_q;
  assign coo_out    = coo_out_q;

endmodule
`default_nettype wire

// File: tb/tb_gcn_data_server.sv
`default_nettype none
// ============================================================================
// Module  : tb_gcn_data_server
// Brief   : Directed self-checking bench for gcn_data_server.
// Rev     : 1.0
// ============================================================================
module tb_gcn_data_server;

  localparam int WR = 96, WC = 3, FR = 6, WW = 5, LN = 8, AW = 13;
  localparam int FB = 512, NC = 6, CB = 3;
  localparam int TOTAL_BEATS = 114;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  load_start, load_valid, load_ready;
  logic [LN*WW-1:0]      load_data;
  logic                  gcn_start, gcn_done, enable_read, busy, addr_error;
  logic [AW-1:0]         read_address;
  logic [WR-1:0][WW-1:0] data_out;
  logic [CB-1:0]         coo_address;
  logic [1:0][CB-1:0]    coo_out;

  int n_tests = 0, n_fail = 0, start_cnt = 0, beats_acc = 0, s0 = 0;
  int e_src [NC] = '{0, 1, 3, 4, 2, 5};
  int e_dst [NC] = '{1, 2, 0, 5, 5, 3};

  gcn_data_server dut (
    .clk          (clk),
    .reset        (reset),
    .load_start   (load_start),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_data    (load_data),
    .gcn_start    (gcn_start),
    .gcn_done     (gcn_done),
    .read_address (read_address),
    .enable_read  (enable_read),
    .data_out     (data_out),
    .coo_address  (coo_address),
    .coo_out      (coo_out),
    .busy         (busy),
    .addr_error   (addr_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (gcn_start) start_cnt++;

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pattern 0 is idx mod 32; pattern 1 skews each row so rows are distinguishable.
  function automatic logic [WW-1:0] elem(input int idx, input int pat);
    int v;
    v = (pat != 0) ? idx + 5 * (idx / WR) : idx;
    return WW'(v % 32);
  endfunction

  function automatic logic [WR*WW-1:0] exp_wm(input int c, input int pat);
    logic [WR*WW-1:0] r;
    for (int i = 0; i < WR; i++) r[i*WW +: WW] = elem(c * WR + i, pat);
    return r;
  endfunction

  function automatic logic [WR*WW-1:0] exp_fm(input int f, input int pat);
    logic [WR*WW-1:0] r;
    for (int i = 0; i < WR; i++) r[i*WW +: WW] = elem(WC * WR + f * WR + i, pat);
    return r;
  endfunction

  function automatic logic [LN*WW-1:0] beat_data(input int b, input int pat);
    logic [LN*WW-1:0] d;
    d = '0;
    if (b < (WC + FR) * WR / LN) begin
      for (int k = 0; k < LN; k++) d[k*WW +: WW] = elem(b * LN + k, pat);
    end else begin
      d[CB-1:0]    = CB'(e_src[b - (WC + FR) * WR / LN]);
      d[2*CB-1:CB] = CB'(e_dst[b - (WC + FR) * WR / LN]);
    end
    return d;
  endfunction

  task automatic start_session();
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
  endtask

  task automatic do_load(input bit toggle, input int pat, input int n_beats);
    int b = 0;
    int guard = 0;
    beats_acc = 0;
    while (b < n_beats && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (toggle && (guard % 2 == 0)) begin
        load_valid = 1'b0;
        load_data  = {8'h00, $urandom};
      end else begin
        load_valid = 1'b1;
        load_data  = beat_data(b, pat);
      end
      #1;
      if (load_valid && load_ready) begin
        b++;
        beats_acc++;
      end
    end
    if (b < n_beats) check_val("load_timeout", 512'(b), 512'(n_beats));
  endtask

  task automatic finish_load(input string tag);
    @(negedge clk); load_valid = 1'b0;
    check_val({tag, "_start_pulse"}, 512'(gcn_start), 512'(1));
    check_val({tag, "_ready_off"},   512'(load_ready), 512'(0));
    @(negedge clk);
    check_val({tag, "_start_drop"},  512'(gcn_start), 512'(0));
    check_val({tag, "_busy_run"},    512'(busy), 512'(1));
    check_val({tag, "_one_pulse"},   512'(start_cnt - s0), 512'(1));
  endtask

  task automatic rd(input int a);
    @(negedge clk); read_address = AW'(a); enable_read = 1'b1;
    @(negedge clk); enable_read = 1'b0;
  endtask

  task automatic done_pulse();
    @(negedge clk); gcn_done = 1'b1;
    @(negedge clk); gcn_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_data = '0;
    gcn_done = 1'b0; read_address = '0; enable_read = 1'b0; coo_address = '0;
    repeat (3) @(negedge clk);
    check_val("rst_ready", 512'(load_ready), 512'(0));
    check_val("rst_busy",  512'(busy), 512'(0));
    check_val("rst_start", 512'(gcn_start), 512'(0));
    check_val("rst_err",   512'(addr_error), 512'(0));
    check_val("rst_data",  512'(data_out), 512'(0));
    check_val("rst_coo",   512'(coo_out), 512'(0));
    reset = 1'b0;

    // Full load, valid held high.
    start_session();
    check_val("wm_ready", 512'(load_ready), 512'(1));
    s0 = start_cnt;
    do_load(1'b0, 0, TOTAL_BEATS);
    check_val("beats_full", 512'(beats_acc), 512'(TOTAL_BEATS));
    finish_load("full");

    rd(1);   check_val("rd_wm1", 512'(data_out), 512'(exp_wm(1, 0)));
    rd(517); check_val("rd_fm5", 512'(data_out), 512'(exp_fm(5, 0)));
    rd(512); check_val("rd_fm0", 512'(data_out), 512'(exp_fm(0, 0)));
    @(negedge clk); read_address = AW'(3);
    @(negedge clk);
    check_val("hold_data", 512'(data_out), 512'(exp_fm(0, 0)));
    check_val("err_clean", 512'(addr_error), 512'(0));

    coo_address = CB'(4);
    @(negedge clk);
    check_val("coo4", 512'(coo_out), 512'({3'd5, 3'd2}));
    coo_address = CB'(0);
    @(negedge clk);
    check_val("coo0", 512'(coo_out), 512'({3'd1, 3'd0}));

    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
    check_val("ls_ign_ready", 512'(load_ready), 512'(0));
    check_val("ls_ign_busy",  512'(busy), 512'(1));

    rd(3); check_val("rd_bad_data", 512'(data_out), 512'(0));
    check_val("rd_bad_err", 512'(addr_error), 512'(1));
    rd(1); check_val("rd_after_bad", 512'(data_out), 512'(exp_wm(1, 0)));
    check_val("err_sticky", 512'(addr_error), 512'(1));
    rd(518); check_val("rd_518", 512'(data_out), 512'(0));

    done_pulse();
    check_val("done_busy", 512'(busy), 512'(0));
    check_val("done_err",  512'(addr_error), 512'(1));

    // Second session with a gappy valid stream.
    start_session();
    check_val("err_cleared", 512'(addr_error), 512'(0));
    s0 = start_cnt;
    do_load(1'b1, 0, TOTAL_BEATS);
    check_val("beats_toggle", 512'(beats_acc), 512'(TOTAL_BEATS));
    finish_load("tog");
    rd(1);   check_val("tog_wm1", 512'(data_out), 512'(exp_wm(1, 0)));
    rd(517); check_val("tog_fm5", 512'(data_out), 512'(exp_fm(5, 0)));
    done_pulse();

    // Abandon a session with an asynchronous reset mid-load.
    start_session();
    s0 = start_cnt;
    do_load(1'b0, 1, 50);
    @(negedge clk); load_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_val("mid_rst_ready", 512'(load_ready), 512'(0));
    check_val("mid_rst_busy",  512'(busy), 512'(0));
    check_val("mid_rst_data",  512'(data_out), 512'(0));
    @(negedge clk); reset = 1'b0;
    done_pulse();
    rd(1);
    check_val("idle_data",  512'(data_out), 512'(0));
    check_val("idle_busy",  512'(busy), 512'(0));
    check_val("idle_ready", 512'(load_ready), 512'(0));
    check_val("idle_start", 512'(start_cnt - s0), 512'(0));

    start_session();
    s0 = start_cnt;
    do_load(1'b0, 1, TOTAL_BEATS);
    finish_load("rec");
    rd(1);   check_val("rec_wm1", 512'(data_out), 512'(exp_wm(1, 1)));
    rd(2);   check_val("rec_wm2", 512'(data_out), 512'(exp_wm(2, 1)));
    rd(517); check_val("rec_fm5", 512'(data_out), 512'(exp_fm(5, 1)));
    rd(514); check_val("rec_fm2", 512'(data_out), 512'(exp_fm(2, 1)));
    check_val("rec_err", 512'(addr_error), 512'(0));
    coo_address = CB'(4);
    @(negedge clk);
    check_val("rec_coo4", 512'(coo_out), 512'({3'd5, 3'd2}));
    coo_address = CB'(6);
    @(negedge clk);
    check_val("coo6_zero", 512'(coo_out), 512'(0));
    check_val("coo6_err",  512'(addr_error), 512'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
